// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for alu_multiciclo.
// The MUL opcode is only decoded when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        MULT   = 2'd1,
        LISTO  = 2'd2
    } estado_t;

endpackage

// File: rtl/multiplicador_serie.sv
// Iterative shift-add multiplier: one partial product per step, ANCHO steps.
// Keeps only the low ANCHO bits of the product.
module multiplicador_serie #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cargar,
    input  logic             paso,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic [ANCHO-1:0] producto,
    output logic             hecho
);

    localparam int CW = $clog2(ANCHO) + 1;

    logic [ANCHO-1:0] a_reg;
    logic [ANCHO-1:0] b_reg;
    logic [ANCHO-1:0] acc;
    logic [CW-1:0]    cnt;

    // Done once all ANCHO iterations have been applied; steps stop there.
    assign hecho    = (cnt == CW'(ANCHO));
    assign producto = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (cargar) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (paso && !hecho) begin
            if (b_reg[0]) begin
                acc <= acc + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Handshaked registered ALU with NZCV-style flags; optional serial multiplier
// enabled by the ALU_MUL_EN macro (opcode 1010 yields 0 in one cycle otherwise).
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int ANCHO      = 32,
    parameter int ANCHO_DESP = $clog2(ANCHO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valido,
    output logic             in_listo,
    input  logic [ANCHO-1:0] operandoA,
    input  logic [ANCHO-1:0] operandoB,
    input  logic [3:0]       seleccionOperacion,
    output logic             out_valido,
    input  logic             out_listo,
    output logic [ANCHO-1:0] resultado,
    output logic             banderaCero,
    output logic             banderaNegativo,
    output logic             banderaAcarreo,
    output logic             banderaDesborde
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready is decoded from state only, and a raised out_valido
    // keeps resultado/flags stable until out_listo completes the transfer.
    estado_t estado, estado_sig;

    logic             aceptar;
    logic             es_mul;
    logic             mul_hecho;
    logic [ANCHO-1:0] producto;
    logic [ANCHO:0]   suma;
    logic [ANCHO:0]   resta;
    logic [ANCHO-1:0] res_alu;
    logic             c_alu;
    logic             v_alu;
    logic [ANCHO-1:0] res_nuevo;
    logic             c_nuevo;
    logic             v_nuevo;
    logic             cargar_res;
    logic [ANCHO_DESP-1:0] desp;

    assign in_listo   = (estado == REPOSO);
    assign out_valido = (estado == LISTO);
    assign aceptar    = (estado == REPOSO) && in_valido;
    assign desp       = operandoB[ANCHO_DESP-1:0];

`ifdef ALU_MUL_EN
    assign es_mul = (seleccionOperacion == OP_MUL);

    multiplicador_serie #(.ANCHO(ANCHO)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .cargar   (aceptar && es_mul),
        .paso     (estado == MULT),
        .a        (operandoA),
        .b        (operandoB),
        .producto (producto),
        .hecho    (mul_hecho)
    );
`else
    assign es_mul    = 1'b0;
    assign mul_hecho = 1'b0;
    assign producto  = '0;
`endif

    always_comb begin
        suma    = {1'b0, operandoA} + {1'b0, operandoB};
        resta   = {1'b0, operandoA} - {1'b0, operandoB};
        res_alu = '0;
        c_alu   = 1'b0;
        v_alu   = 1'b0;
        case (seleccionOperacion)
            OP_ADD: begin
                res_alu = suma[ANCHO-1:0];
                c_alu   = suma[ANCHO];
                v_alu   = (operandoA[ANCHO-1] == operandoB[ANCHO-1]) &&
                          (suma[ANCHO-1] != operandoA[ANCHO-1]);
            end
            OP_SUB: begin
                res_alu = resta[ANCHO-1:0];
                c_alu   = resta[ANCHO];
                v_alu   = (operandoA[ANCHO-1] != operandoB[ANCHO-1]) &&
                          (resta[ANCHO-1] != operandoA[ANCHO-1]);
            end
            OP_AND: res_alu = operandoA & operandoB;
            OP_OR:  res_alu = operandoA | operandoB;
            OP_SLT: res_alu = {{(ANCHO-1){1'b0}}, resta[ANCHO]};
            OP_XOR: res_alu = operandoA ^ operandoB;
            OP_SLL: res_alu = operandoA << desp;
            OP_SRL: res_alu = operandoA >> desp;
            OP_SRA: res_alu = $signed(operandoA) >>> desp;
            OP_NOR: res_alu = ~(operandoA | operandoB);
            default: res_alu = '0;
        endcase
    end

    // The multiplier product carries no carry/overflow meaning.
    always_comb begin
        res_nuevo = res_alu;
        c_nuevo   = c_alu;
        v_nuevo   = v_alu;
        if (estado == MULT) begin
            res_nuevo = producto;
            c_nuevo   = 1'b0;
            v_nuevo   = 1'b0;
        end
    end

    assign cargar_res = (aceptar && !es_mul) || ((estado == MULT) && mul_hecho);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resultado       <= '0;
            banderaCero     <= 1'b0;
            banderaNegativo <= 1'b0;
            banderaAcarreo  <= 1'b0;
            banderaDesborde <= 1'b0;
        end else if (cargar_res) begin
            resultado       <= res_nuevo;
            banderaCero     <= (res_nuevo == '0);
            banderaNegativo <= res_nuevo[ANCHO-1];
            banderaAcarreo  <= c_nuevo;
            banderaDesborde <= v_nuevo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: if (in_valido) estado_sig = es_mul ? MULT : LISTO;
            MULT:   if (mul_hecho) estado_sig = LISTO;
            LISTO:  if (out_listo) estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases plus random ops
// compared against an arithmetic reference model through a result queue.
module tb_alu_multiciclo;

    localparam int ANCHO = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valido;
    logic             in_listo;
    logic [ANCHO-1:0] operandoA;
    logic [ANCHO-1:0] operandoB;
    logic [3:0]       seleccionOperacion;
    logic             out_valido;
    logic             out_listo;
    logic [ANCHO-1:0] resultado;
    logic             banderaCero;
    logic             banderaNegativo;
    logic             banderaAcarreo;
    logic             banderaDesborde;

    int total = 0;
    int bad   = 0;
    logic [ANCHO+3:0] exp_q[$];

    alu_multiciclo #(.ANCHO(ANCHO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valido          (in_valido),
        .in_listo           (in_listo),
        .operandoA          (operandoA),
        .operandoB          (operandoB),
        .seleccionOperacion (seleccionOperacion),
        .out_valido         (out_valido),
        .out_listo          (out_listo),
        .resultado          (resultado),
        .banderaCero        (banderaCero),
        .banderaNegativo    (banderaNegativo),
        .banderaAcarreo     (banderaAcarreo),
        .banderaDesborde    (banderaDesborde)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {result, Z, N, C, V} from plain integer arithmetic.
    function automatic logic [ANCHO+3:0] modelo(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint unsigned ua, ub, full;
        longint sa, sb, s;
        logic [31:0] r;
        logic c, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        r = 0; c = 0; v = 0;
        case (op)
            4'd0: begin
                full = ua + ub; r = full[31:0]; c = (full > 64'hFFFF_FFFF);
                s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b; c = (ua < ub);
                s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a << b[4:0];
            4'd7: r = a >> b[4:0];
            4'd8: r = $signed(a) >>> b[4:0];
            4'd9: r = ~(a | b);
            4'd10: if (MUL_EN) begin full = ua * ub; r = full[31:0]; end
            default: r = 0;
        endcase
        return {r, (r == 0), r[31], c, v};
    endfunction

    // driver: issue one op, await result, optionally stall the consumer
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [ANCHO+3:0] esperado;
        logic [31:0] r_snap;
        logic [3:0]  f_snap;
        int lat, exp_lat;
        exp_lat = (op == 4'd10 && MUL_EN) ? ANCHO + 1 : 1;
        lat = 0;
        while (!in_listo && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("in_listo_idle", in_listo, 1);
        seleccionOperacion = op; operandoA = a; operandoB = b; in_valido = 1'b1;
        exp_q.push_back(modelo(op, a, b));
        @(posedge clk); #1;
        in_valido = 1'b0; operandoA = $urandom; operandoB = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valido) check("in_listo_busy", in_listo, 0);
        end while (!out_valido && lat < 200);
        check("latency", lat, exp_lat);
        esperado = exp_q.pop_front();
        check("resultado", resultado, esperado[ANCHO+3:4]);
        check("flags_zncv", {banderaCero, banderaNegativo, banderaAcarreo, banderaDesborde},
              esperado[3:0]);
        r_snap = resultado;
        f_snap = {banderaCero, banderaNegativo, banderaAcarreo, banderaDesborde};
        for (int i = 0; i < hold; i++) begin
            in_valido = 1'b1; operandoA = $urandom; operandoB = $urandom;
            seleccionOperacion = 4'($urandom_range(0, 9));
            @(negedge clk);
            check("hold_result", resultado, r_snap);
            check("hold_flags", {banderaCero, banderaNegativo, banderaAcarreo, banderaDesborde},
                  f_snap);
            check("hold_valid", out_valido, 1);
            check("hold_in_listo", in_listo, 0);
        end
        in_valido = 1'b0;
        out_listo = 1'b1;
        @(posedge clk); #1;
        out_listo = 1'b0;
        @(negedge clk);
        check("post_hs_in_listo", in_listo, 1);
        check("post_hs_out_valido", out_valido, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; in_valido = 1'b0; out_listo = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        operandoA = '0; operandoB = '0; seleccionOperacion = '0;
        reset_dut();
        check("rst_out_valido", out_valido, 0);
        check("rst_resultado", resultado, 0);
        check("rst_flags", {banderaCero, banderaNegativo, banderaAcarreo, banderaDesborde}, 0);
        check("rst_in_listo", in_listo, 1);

        do_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op(4'd1, 32'h8000_0000, 32'h0000_0001, 0);
        do_op(4'd4, 32'd3, 32'd5, 0);
        do_op(4'd4, 32'd5, 32'd3, 0);
        do_op(4'd8, 32'hF000_0000, 32'd4, 0);
        do_op(4'd6, 32'd1, 32'd31, 0);
        do_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 0);
        do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5);
        do_op(4'd1, 32'd0, 32'd1, 0);
        do_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(op, a, b, $urandom_range(0, 2));
        end

        // reset while a result is waiting in LISTO
        seleccionOperacion = 4'd0; operandoA = 32'd7; operandoB = 32'd9; in_valido = 1'b1;
        @(posedge clk); #1 in_valido = 1'b0;
        @(negedge clk);
        check("abort_listo_pre", out_valido, 1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_listo_valid", out_valido, 0);
            check("abort_listo_in_listo", in_listo, 1);
        end
        check("abort_listo_result", resultado, 0);

`ifdef ALU_MUL_EN
        // reset at iteration 10 of a multiply
        seleccionOperacion = 4'd10; operandoA = 32'h0000_FFFF; operandoB = 32'h0001_0001;
        in_valido = 1'b1;
        @(posedge clk); #1 in_valido = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_mul_in_listo", in_listo, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("abort_mul_valid", out_valido, 0);
        end
        check("abort_mul_result", resultado, 0);
        do_op(4'd10, 32'd12345, 32'd678, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
